// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; also executes MTHI/MTLO.
// Latency: MTHI/MTLO write at the accept edge; mult/div done pulses DATA_WIDTH+1 cycles after accept.
// Backpressure: in_ready low from accept until the cycle after done; flush aborts and frees the unit.
module alu_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]         p_hi;      // partial product high half / division remainder
    logic [W-1:0]         p_lo;      // multiplier being shifted out / dividend-quotient shift reg
    logic [W-1:0]         mcand;     // multiplicand / divisor magnitude
    logic                 is_div;
    logic                 neg_q;     // product or quotient must be negated
    logic                 neg_r;     // remainder must be negated (follows dividend)
    logic                 div_zero;

    logic                 accept;
    logic                 s1, s2;
    logic [W-1:0]         mag1, mag2;
    logic [W:0]           add_sum;
    logic [W:0]           shl;
    logic [W-1:0]         diff;
    logic                 ge;
    logic [2*W-1:0]       prod_mag, prod_fix;
    logic [W-1:0]         q_fix, r_fix;

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready & ~flush;
    // The result is already in hi/lo when DONE is entered; flush still masks the pulse.
    assign done     = (state == DONE) & ~flush;

    // Operand magnitudes and one radix-2 step for both multiply and divide.
    always_comb begin
        s1       = ~op[0] & op1[W-1];
        s2       = ~op[0] & op2[W-1];
        mag1     = s1 ? -op1 : op1;
        mag2     = s2 ? -op2 : op2;
        add_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        shl      = {p_hi, p_lo[W-1]};
        ge       = (shl >= {1'b0, mcand});
        // Only the low W bits survive, and a true remainder always fits in W bits.
        diff     = shl[W-1:0] - mcand;
        prod_mag = {p_hi, p_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        q_fix    = div_zero ? '1 : (neg_q ? -p_lo : p_lo);
        r_fix    = neg_r ? -p_hi : p_hi;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: flush wins over everything; the counter-exhausted CALC cycle commits.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && !op[2]) state_nx = CALC;
            CALC: begin
                if (flush)           state_nx = IDLE;
                else if (cnt == '0)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration datapath, counter and HI/LO commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            mcand    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            case (op)
                3'b100: hi <= op1;
                3'b101: lo <= op1;
                3'b000, 3'b001, 3'b010, 3'b011: begin
                    cnt      <= CNT_WIDTH'(DATA_WIDTH);
                    is_div   <= op[1];
                    p_hi     <= '0;
                    p_lo     <= op[1] ? mag1 : mag2;
                    mcand    <= op[1] ? mag2 : mag1;
                    neg_q    <= s1 ^ s2;
                    neg_r    <= s1;
                    div_zero <= (op2 == '0);
                end
                default: ;
            endcase
        end else if (state == CALC && !flush) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_WIDTH'(1);
                if (is_div) begin
                    p_hi <= ge ? diff : shl[W-1:0];
                    p_lo <= {p_lo[W-2:0], ge};
                end else begin
                    p_hi <= add_sum[W:1];
                    p_lo <= {add_sum[0], p_lo[W-1:1]};
                end
            end else if (is_div) begin
                hi <= r_fix;
                lo <= q_fix;
            end else begin
                hi <= prod_fix[2*W-1:W];
                lo <= prod_fix[W-1:0];
            end
        end
    end

`ifndef SYNTHESIS
    // Report unknown or reserved op codes presented with a request.
    always @(posedge clk) begin
        if (in_valid && $isunknown(op))
            $display("alu_muldiv: unknown op code while in_valid at %0t", $time);
        else if (accept && op[2:1] == 2'b11)
            $display("alu_muldiv: reserved op %b accepted at %0t", op, $time);
    end
`endif

endmodule
